// File: rtl/gcd_stein.sv
// Multi-cycle binary (Stein) GCD engine with start/ready/done handshake,
// zero-operand short-cut and a saturating per-operation cycle count.
module gcd_stein #(
  parameter int WIDTH = 32,
  localparam int CW = $clog2(4*WIDTH+8)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             ready,
  output logic [WIDTH-1:0] out,
  output logic             done,
  output logic [CW-1:0]    cycles
);

  localparam int KW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, STRIP, REDUCE, FINISH} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a, a_next, b, b_next;
  logic [KW-1:0]    k, k_next;
  logic [CW-1:0]    cnt, cnt_next, cnt_inc;
  logic [WIDTH-1:0] out_next;
  logic             done_next;
  logic [CW-1:0]    cycles_next;

  assign ready   = (state == IDLE);
  assign cnt_inc = (cnt == {CW{1'b1}}) ? cnt : cnt + {{(CW-1){1'b0}}, 1'b1};

  always_comb begin
    state_next  = state;
    a_next      = a;
    b_next      = b;
    k_next      = k;
    cnt_next    = cnt;
    out_next    = out;
    done_next   = 1'b0;
    cycles_next = cycles;
    case (state)
      IDLE: begin
        if (start) begin
          a_next   = in1;
          b_next   = in2;
          k_next   = '0;
          cnt_next = '0;
          if (in1 == '0) begin
            a_next     = in2;
            state_next = FINISH;
          end else if (in2 == '0) begin
            a_next     = in1;
            state_next = FINISH;
          end else begin
            state_next = STRIP;
          end
        end else begin
          state_next = IDLE;
        end
      end
      STRIP: begin
        // Common factors of two are counted in k and restored at the end.
        cnt_next = cnt_inc;
        if (!a[0] && !b[0]) begin
          a_next = a >> 1;
          b_next = b >> 1;
          k_next = k + {{(KW-1){1'b0}}, 1'b1};
        end else if (!a[0]) begin
          a_next = a >> 1;
        end else begin
          state_next = REDUCE;
        end
      end
      REDUCE: begin
        // a stays odd; swapping on b<a keeps the subtraction non-negative.
        cnt_next = cnt_inc;
        if (b == '0) begin
          state_next = FINISH;
        end else if (!b[0]) begin
          b_next = b >> 1;
        end else if (b >= a) begin
          b_next = b - a;
        end else begin
          a_next = b;
          b_next = a - b;
        end
      end
      FINISH: begin
        cnt_next    = cnt_inc;
        out_next    = a << k;
        done_next   = 1'b1;
        cycles_next = cnt_inc;
        state_next  = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      a      <= '0;
      b      <= '0;
      k      <= '0;
      cnt    <= '0;
      out    <= '0;
      done   <= 1'b0;
      cycles <= '0;
    end else begin
      state  <= state_next;
      a      <= a_next;
      b      <= b_next;
      k      <= k_next;
      cnt    <= cnt_next;
      out    <= out_next;
      done   <= done_next;
      cycles <= cycles_next;
    end
  end

endmodule

// File: tb/tb_gcd_stein.sv
// Self-checking bench for gcd_stein: directed cases plus random sweeps at
// WIDTH=32 and WIDTH=8 against a Euclid reference model.
module tb_gcd_stein;

  localparam int CW32 = $clog2(4*32+8);
  localparam int CW8  = $clog2(4*8+8);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic            start, start8;
  logic [31:0]     in1, in2, out;
  logic [7:0]      in1_8, in2_8, out8;
  logic            ready, done, ready8, done8;
  logic [CW32-1:0] cycles;
  logic [CW8-1:0]  cycles8;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] last_out = 32'd0;

  gcd_stein #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start), .in1(in1), .in2(in2),
    .ready(ready), .out(out), .done(done), .cycles(cycles)
  );

  gcd_stein #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .in1(in1_8), .in2(in2_8),
    .ready(ready8), .out(out8), .done(done8), .cycles(cycles8)
  );

  function automatic longint unsigned gcd_ref(longint unsigned x, longint unsigned y);
    longint unsigned t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present operands with start; caller is either before an edge in IDLE or in the done cycle.
  task automatic launch32(input logic [31:0] x, input logic [31:0] y);
    in1 = x;
    in2 = y;
    start = 1'b1;
    check("ready_before_accept", {63'd0, ready}, 64'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    in1 = $urandom;
    in2 = $urandom;
    check("ready_falls", {63'd0, ready}, 64'd0);
    check("done_clears", {63'd0, done}, 64'd0);
    check("out_held", {32'd0, out}, {32'd0, last_out});
  endtask

  task automatic wait32(input logic [31:0] exp, input int exp_cyc, input bit junk);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 4*32+20) begin
      @(posedge clk);
      n++;
      #1;
      if (done) begin
        seen = 1'b1;
      end else begin
        check("ready_busy", {63'd0, ready}, 64'd0);
        if (junk) begin
          start = 1'($urandom_range(0, 1));
          in1 = $urandom;
          in2 = $urandom;
        end
      end
    end
    start = 1'b0;
    check("done_seen", {63'd0, seen}, 64'd1);
    if (seen) begin
      check("out", {32'd0, out}, {32'd0, exp});
      check("cycles_vs_edges", 64'(cycles), 64'(n));
      check("cycles_bound", {63'd0, (cycles <= CW32'(4*32+8))}, 64'd1);
      check("ready_with_done", {63'd0, ready}, 64'd1);
      if (exp_cyc >= 0) check("cycles_exact", 64'(cycles), 64'(exp_cyc));
      last_out = exp;
    end
  endtask

  task automatic op8(input logic [7:0] x, input logic [7:0] y);
    int n;
    bit seen;
    in1_8 = x;
    in2_8 = y;
    start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 4*8+20) begin
      @(posedge clk);
      n++;
      #1;
      if (done8) seen = 1'b1;
    end
    check("done8_seen", {63'd0, seen}, 64'd1);
    if (seen) begin
      check("out8", {56'd0, out8}, gcd_ref(64'(x), 64'(y)));
      check("cycles8_vs_edges", 64'(cycles8), 64'(n));
      check("cycles8_bound", {63'd0, (cycles8 <= CW8'(4*8+8))}, 64'd1);
    end
  endtask

  initial begin
    logic [31:0] x, y;
    bit spurious;
    reset = 1'b1;
    start = 1'b0; start8 = 1'b0;
    in1 = '0; in2 = '0; in1_8 = '0; in2_8 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", {32'd0, out}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_cycles", 64'(cycles), 64'd0);
    check("rst_ready", {63'd0, ready}, 64'd1);
    check("rst_ready8", {63'd0, ready8}, 64'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    launch32(32'd64, 32'd212);        wait32(32'd4, 18, 1'b0);
    launch32(32'd0, 32'd212);         wait32(32'd212, 1, 1'b1);
    launch32(32'd0, 32'd0);           wait32(32'd0, 1, 1'b1);
    launch32(32'd9, 32'd0);           wait32(32'd9, 1, 1'b1);
    launch32(32'd7, 32'd7);           wait32(32'd7, 4, 1'b1);
    launch32(32'h8000_0000, 32'h8000_0000); wait32(32'h8000_0000, 35, 1'b1);
    launch32(32'd64, 32'd212);        wait32(32'd4, 18, 1'b1);
    launch32(32'd21, 32'd14);         wait32(32'd7, -1, 1'b1);

    // Abort an operation while it is reducing.
    launch32(32'd64, 32'd212);
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort_out", {32'd0, out}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_cycles", 64'(cycles), 64'd0);
    check("abort_ready", {63'd0, ready}, 64'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    last_out = 32'd0;
    spurious = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) spurious = 1'b1;
    end
    check("no_spurious_done", {63'd0, spurious}, 64'd0);
    launch32(32'd12, 32'd18);         wait32(32'd6, -1, 1'b0);

    for (int i = 0; i < 150; i++) begin
      x = $urandom << $urandom_range(0, 8);
      y = $urandom << $urandom_range(0, 8);
      if ($urandom_range(0, 15) == 0) x = 32'd0;
      if ($urandom_range(0, 15) == 0) y = 32'd0;
      if ($urandom_range(0, 3) == 0) begin
        x = 32'($urandom_range(0, 5000));
        y = 32'($urandom_range(0, 5000));
      end
      launch32(x, y);
      wait32(32'(gcd_ref(64'(x), 64'(y))), -1, 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    op8(8'd255, 8'd255);
    op8(8'd128, 8'd128);
    op8(8'd0, 8'd77);
    for (int i = 0; i < 150; i++) begin
      op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gcd_stein.md
# gcd_stein

Parametrised multi-cycle GCD engine using the binary (Stein) algorithm. It is the successor to the subtractive `gcd` block and adds four things: a start/ready/done handshake for back-to-back operands, zero-operand handling, power-of-two factoring with shifts, and a per-operation cycle count. It sits as a standalone arithmetic unit driven by a controller or testbench on a single clock.

## Interface

- `WIDTH`, default 32: operand and result width in bits, 2 or more.
- `CW`, localparam `$clog2(4*WIDTH+8)`: width of the cycle counter.
- `clk`  input  1: clock, rising edge.
- `reset`  input  1: asynchronous, active-high reset. One clock; the reset is asynchronous and active-high.
- `start`  input  1: request; accepted on an edge where `start && ready`.
- `in1`  input  WIDTH: operand A, sampled on the accept edge only.
- `in2`  input  WIDTH: operand B, sampled on the accept edge only.
- `ready`  output  1: combinational, `state == IDLE`.
- `out`  output  WIDTH: GCD result. Registered; held until the next result is written.
- `done`  output  1: registered one-cycle pulse; `out` and `cycles` are valid in the same cycle.
- `cycles`  output  CW: number of edges from the accept edge to the edge that set `done`, inclusive. Saturates at all-ones. Held.

## Operation

- States are IDLE, STRIP, REDUCE and FINISH. Internal registers are `a`, `b` (WIDTH), `k` (`$clog2(WIDTH)` bits) and `cnt` (CW).
- Reset drives `state` to IDLE, `out`, `done` and `cycles` to 0, and clears `a`, `b`, `k` and `cnt`.
- **IDLE, on accept:**
  - Load `a=in1`, `b=in2`, `k=0`, `cnt=0`.
  - If `in1==0`, load `a=in2` and go to FINISH.
  - Else if `in2==0`, load `a=in1` and go to FINISH.
  - Otherwise go to STRIP.
  - `start` while not IDLE is ignored; there is no queueing.
- **STRIP, one action per edge:**
  - If `a` and `b` are both even: `a>>=1`, `b>>=1`, `k++`.
  - Else if `a` is even: `a>>=1`.
  - Else (`a` odd): go to REDUCE with no data change.
- **REDUCE, invariant `a` odd, one action per edge:**
  - If `b==0`: go to FINISH.
  - Else if `b` is even: `b>>=1`.
  - Else if `b>=a`: `b<=b-a`.
  - Else: `a<=b`, `b<=a-b`.
  - Subtraction is unsigned WIDTH-bit and never underflows by construction.
- **FINISH:**
  - `out<=a<<k`, `done<=1`, `cycles<=sat(cnt+1)`, go to IDLE.
  - No overflow is possible, since `k` never exceeds the trailing-zero count of the smaller nonzero operand.
- `cnt` increments, saturating, on every edge spent in STRIP, REDUCE or FINISH.
- `done` is cleared on every edge other than the FINISH edge.
- GCD(0,0) is 0. GCD(x,0) and GCD(0,x) are x.

## Timing

- Accept edge E0: `ready` falls in the next cycle.
- FINISH edge En: `done=1`, `out` and `cycles` update, and `ready=1`, all in the same cycle.
- A new `start` may be accepted in the `done` cycle. `done` still deasserts on the next edge, and the previous `out` is held until the new FINISH.
- Latency is data-dependent:
  - Zero-operand case: exactly 1 edge (`cycles=1`).
  - General case: worst case is under `4*WIDTH+8` edges.
- Asynchronous `reset` mid-operation aborts immediately. All outputs go to their reset values, and `ready=1` once reset is released. No `done` is produced for the aborted operation.
- Inputs are not required to be stable after the accept edge.

## Test plan

- Reset released, `in1=64`, `in2=212`, `start` pulsed -> `done` after the 18th edge from accept, `out=4`, `cycles=18`. `ready` is low throughout and returns high with `done`.
- `in1=0`, `in2=212` -> `out=212`, `cycles=1`. Then `in1=0`, `in2=0` -> `out=0`, `cycles=1`. Then `in1=9`, `in2=0` -> `out=9`.
- `in1=in2=7` -> `out=7`, `cycles=4`. With WIDTH=32 and `in1=in2=32'h80000000` -> `out=32'h80000000`, `cycles=35`.
- Back-to-back: (64,212), then `start` held high with (21,14) presented in the `done` cycle -> second operation accepted immediately, `out=7`. `start` toggled while busy -> no effect on either result.
- `reset` asserted mid-REDUCE -> `out=0`, `done=0`, `cycles=0`, `ready=1` during reset. No spurious `done` after release. A fresh (12,18) -> `out=6`.
- Random sweep at WIDTH=8 and WIDTH=32 against a Euclid reference model -> `out` matches on every pair, and `cycles` never exceeds `4*WIDTH+8`.
